instruction_encoder: RTL

Encodes RISC-V instruction fields plus a signed 64-bit immediate into a 32-bit RV64IM instruction word. It is the inverse of the immediate extractor and uses the same format-select codes. It sits between the test/boot program generator and instruction memory: it accepts one field set per valid/ready handshake, registers the encoded word with a running word address, and range-checks every immediate so that unencodable values are caught rather than silently truncated.

---
 rtl/instruction_encoder.sv | 115 +++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// RV64IM instruction encoder: packs fields plus a signed immediate into a 32-bit word,
// range-checks the immediate, and registers the word with a running byte address.
module instruction_encoder #(
   parameter int                    ADDR_WIDTH = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            selection,
   input  logic [6:0]            opcode,
   input  logic [4:0]            rd,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   input  logic [2:0]            funct3,
   input  logic [6:0]            funct7,
   input  logic [63:0]           immediate,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           instruction,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  error,
   output logic [7:0]            err_count
);

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_U = 3'd2,
      FMT_S = 3'd3,
      FMT_B = 3'd4,
      FMT_J = 3'd5
   } fmt_t;

   logic [ADDR_WIDTH-1:0] next_addr;
   logic [31:0]           enc;
   logic                  fault;
   logic                  accept;
   logic                  fits_12;
   logic                  fits_b;
   logic                  fits_u;
   logic                  fits_j;

   // Range checks reduce to "upper bits are all copies of the sign bit".
   assign fits_12 = (immediate[63:11] == {53{immediate[63]}});
   assign fits_b  = (immediate[63:12] == {52{immediate[63]}}) && !immediate[0];
   assign fits_u  = (immediate[11:0] == 12'h000) && (immediate[63:31] == {33{immediate[63]}});
   assign fits_j  = (immediate[63:20] == {44{immediate[63]}}) && !immediate[0];

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      enc   = '0;
      fault = 1'b0;
      case (selection)
         FMT_R: enc = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            enc   = {immediate[11:0], rs1, funct3, rd, opcode};
            fault = !fits_12;
         end
         FMT_U: begin
            enc   = {immediate[31:12], rd, opcode};
            fault = !fits_u;
         end
         FMT_S: begin
            enc   = {immediate[11:5], rs2, rs1, funct3, immediate[4:0], opcode};
            fault = !fits_12;
         end
         FMT_B: begin
            enc   = {immediate[12], immediate[10:5], rs2, rs1, funct3,
                     immediate[4:1], immediate[11], opcode};
            fault = !fits_b;
         end
         FMT_J: begin
            enc   = {immediate[20], immediate[10:1], immediate[11], immediate[19:12], rd, opcode};
            fault = !fits_j;
         end
         default: fault = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid   <= 1'b0;
         instruction <= '0;
         address     <= BASE_ADDR;
         next_addr   <= BASE_ADDR;
         error       <= 1'b0;
         err_count   <= '0;
      end else if (clear) begin
         // Clear wins over a same-cycle accept; that field set is dropped.
         out_valid   <= 1'b0;
         instruction <= '0;
         address     <= BASE_ADDR;
         next_addr   <= BASE_ADDR;
         error       <= 1'b0;
         err_count   <= '0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         instruction <= fault ? 32'h0000_0000 : enc;
         address     <= next_addr;
         next_addr   <= next_addr + ADDR_WIDTH'(4);
         if (fault) begin
            error <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
